// File: rtl/tage_update_queue.sv
// tage_update_queue: buffers retired-branch TAGE update records and turns each
// record into a sequence of single-port table writes (provider, optional
// allocation, then one useful-decrement per remaining mask bit).
module tage_update_queue #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 8,
  parameter int TAGW  = 8
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            OutDateAble,
  input  logic [31:0]     OutUpDatePc,
  input  logic [2:0]      OutUpNum,
  input  logic [2:0]      OutUpDate,
  input  logic [2:0]      OutUpCnt,
  input  logic            NewDateAble,
  input  logic [2:0]      NewUpNum,
  input  logic [2:0]      NewUpDate,
  input  logic [2:0]      NewUpCnt,
  input  logic            NewCnt1Able,
  input  logic            NewCnt2Able,
  input  logic            NewCnt3Able,
  input  logic            NewCnt4Able,
  input  logic            NewCnt5Able,
  input  logic            NewCnt6Able,
  input  logic [2:0]      NewCnt1Date,
  input  logic [2:0]      NewCnt2Date,
  input  logic [2:0]      NewCnt3Date,
  input  logic [2:0]      NewCnt4Date,
  input  logic [2:0]      NewCnt5Date,
  input  logic [2:0]      NewCnt6Date,
  input  logic            TabWReady,
  output logic            TabWEn,
  output logic [2:0]      TabWSel,
  output logic [IDXW-1:0] TabWIdx,
  output logic [TAGW-1:0] TabWTag,
  output logic [2:0]      TabWCtr,
  output logic [2:0]      TabWUseful,
  output logic [2:0]      TabWMask,
  output logic            UpdFull,
  output logic            UpdBusy,
  output logic [7:0]      UpdDropCnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Only the index/tag slices of the PC are kept per record.
  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic [2:0]      pnum;
    logic [2:0]      pctr;
    logic [2:0]      puse;
    logic            aable;
    logic [2:0]      anum;
    logic [2:0]      actr;
    logic [2:0]      ause;
    logic [6:1]      dmask;
    logic [6:1][2:0] dval;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_PROV, S_ALLOC, S_DEC} state_t;

  rec_t            r_q [DEPTH];
  logic [AW-1:0]   r_head, r_tail;
  logic [AW:0]     r_count;
  logic [7:0]      r_drop;
  state_t          r_state;
  rec_t            r_wrec;

  logic            r_wen;
  logic [2:0]      r_wsel, r_wctr, r_wuse, r_wmask;
  logic [IDXW-1:0] r_widx;
  logic [TAGW-1:0] r_wtag;

  state_t          w_nstate;
  rec_t            w_nrec, w_inrec;
  logic            w_pop, w_done, w_enq;
  logic [6:1]      w_dable;
  logic [6:1][2:0] w_dval;
  logic            w_wen;
  logic [2:0]      w_wsel, w_wctr, w_wuse, w_wmask;
  logic [IDXW-1:0] w_widx;
  logic [TAGW-1:0] w_wtag;
  logic            w_unused_pc;

  assign w_unused_pc = ^{OutUpDatePc[31:IDXW+TAGW+2], OutUpDatePc[1:0]};

  assign w_dable = {NewCnt6Able, NewCnt5Able, NewCnt4Able,
                    NewCnt3Able, NewCnt2Able, NewCnt1Able};
  assign w_dval  = {NewCnt6Date, NewCnt5Date, NewCnt4Date,
                    NewCnt3Date, NewCnt2Date, NewCnt1Date};

  // Capture an incoming record; an allocation into Tk suppresses the Tk decrement.
  always_comb begin
    w_inrec       = '0;
    w_inrec.idx   = OutUpDatePc[IDXW+1:2];
    w_inrec.tag   = OutUpDatePc[IDXW+TAGW+1:IDXW+2];
    w_inrec.pnum  = OutUpNum;
    w_inrec.pctr  = OutUpDate;
    w_inrec.puse  = OutUpCnt;
    w_inrec.aable = NewDateAble;
    w_inrec.anum  = NewUpNum;
    w_inrec.actr  = NewUpDate;
    w_inrec.ause  = NewUpCnt;
    w_inrec.dval  = w_dval;
    for (int k = 1; k <= 6; k++)
      w_inrec.dmask[k] = w_dable[k] && !(NewDateAble && (NewUpNum == 3'(k)));
  end

  // Next-state logic: advance only on an accepted write; DONE refills from the queue.
  always_comb begin
    w_nstate = r_state;
    w_nrec   = r_wrec;
    w_pop    = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_pop = 1'b1;
      S_PROV:  if (TabWReady) begin
                 if (r_wrec.aable)            w_nstate = S_ALLOC;
                 else if (r_wrec.dmask != '0) w_nstate = S_DEC;
                 else                         w_done   = 1'b1;
               end
      S_ALLOC: if (TabWReady) begin
                 if (r_wrec.dmask != '0) w_nstate = S_DEC;
                 else                    w_done   = 1'b1;
               end
      S_DEC:   if (TabWReady) begin
                 w_nrec.dmask = r_wrec.dmask & (r_wrec.dmask - 6'd1);
                 if (w_nrec.dmask == '0) w_done = 1'b1;
               end
      default: w_nstate = S_IDLE;
    endcase
    if (w_done) begin
      if (r_count != '0) w_pop    = 1'b1;
      else               w_nstate = S_IDLE;
    end
    if (w_pop) begin
      w_nrec   = r_q[r_head];
      w_nstate = S_PROV;
    end
  end

  // Write port contents for the next cycle; identical inputs while stalled keep them stable.
  always_comb begin
    w_wen   = 1'b0;
    w_wsel  = 3'd0;
    w_wctr  = 3'd0;
    w_wuse  = 3'd0;
    w_wmask = 3'd0;
    w_widx  = '0;
    w_wtag  = '0;
    if (w_nstate != S_IDLE) begin
      w_wen  = 1'b1;
      w_widx = w_nrec.idx;
      w_wtag = w_nrec.tag;
    end
    case (w_nstate)
      S_PROV: begin
        w_wsel  = w_nrec.pnum;
        w_wctr  = w_nrec.pctr;
        w_wuse  = w_nrec.puse;
        w_wmask = (w_nrec.pnum == 3'd0) ? 3'b001 : 3'b011;
      end
      S_ALLOC: begin
        w_wsel  = w_nrec.anum;
        w_wctr  = w_nrec.actr;
        w_wuse  = w_nrec.ause;
        w_wmask = 3'b111;
      end
      S_DEC: begin
        // Descending scan so the lowest set bit is the one that sticks.
        for (int k = 6; k >= 1; k--) begin
          if (w_nrec.dmask[k]) begin
            w_wsel = 3'(k);
            w_wuse = w_nrec.dval[k];
          end
        end
        w_wmask = 3'b010;
      end
      default: ;
    endcase
  end

  // A full queue still takes a record in the cycle it pops.
  assign w_enq = OutDateAble && ((r_count != CNT_FULL) || w_pop);

  // Record storage; contents need no reset since count gates every read.
  always_ff @(posedge Clk) begin
    if (!Rest && w_enq) r_q[r_tail] <= w_inrec;
  end

  // Pointers, occupancy, drop counter, FSM and registered write port.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_state <= S_IDLE;
      r_wrec  <= '0;
      r_wen   <= 1'b0;
      r_wsel  <= '0;
      r_widx  <= '0;
      r_wtag  <= '0;
      r_wctr  <= '0;
      r_wuse  <= '0;
      r_wmask <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_ONE;
      if (w_pop) r_head <= r_head + PTR_ONE;
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: ;
      endcase
      if (OutDateAble && !w_enq && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      r_state <= w_nstate;
      r_wrec  <= w_nrec;
      r_wen   <= w_wen;
      r_wsel  <= w_wsel;
      r_widx  <= w_widx;
      r_wtag  <= w_wtag;
      r_wctr  <= w_wctr;
      r_wuse  <= w_wuse;
      r_wmask <= w_wmask;
    end
  end

  assign TabWEn     = r_wen;
  assign TabWSel    = r_wsel;
  assign TabWIdx    = r_widx;
  assign TabWTag    = r_wtag;
  assign TabWCtr    = r_wctr;
  assign TabWUseful = r_wuse;
  assign TabWMask   = r_wmask;
  assign UpdFull    = (r_count == CNT_FULL);
  assign UpdBusy    = (r_count != '0) || (r_state != S_IDLE);
  assign UpdDropCnt = r_drop;

endmodule

// File: doc/tage_update_queue.md
# tage_update_queue

Buffers retired-branch update records produced by the FTQ update logic and serializes them into single-write-port TAGE table writes. It sits between the FTQ (producer of provider/allocation/useful-decrement updates) and the base/tagged TAGE tables (T0..T6). Back-pressure is reported to ctrl so fetch can stall the FTQ.

## Interface
- DEPTH, 4: record queue entries, a power of 2 and at least 2.
- IDXW, 8: table index width.
- TAGW, 8: tag width.
- Clk  in  1  clock; all state updates on the rising edge.
- Rest  in  1  reset; synchronous, active-high.
- OutDateAble  in  1  provider update valid; this is the record-enqueue strobe.
- OutUpDatePc  in  32  branch PC.
- OutUpNum  in  3  provider table (0 = base T0, 1..6 = tagged).
- OutUpDate  in  3  new provider counter value.
- OutUpCnt  in  3  new provider useful value.
- NewDateAble  in  1  allocation requested.
- NewUpNum  in  3  allocation table (1..6).
- NewUpDate  in  3  allocation initial counter.
- NewUpCnt  in  3  allocation initial useful.
- NewCntkAble, k=1..6  in  1 each  decrement useful of Tk.
- NewCntkDate, k=1..6  in  3 each  new useful value for Tk.
- TabWReady  in  1  tables accept a write this cycle; 0 when the prediction read owns the port.
- TabWEn  out  1  write strobe.
- TabWSel  out  3  target table 0..6.
- TabWIdx  out  IDXW  PC[IDXW+1:2].
- TabWTag  out  TAGW  PC[IDXW+TAGW+1:IDXW+2].
- TabWCtr  out  3  counter value.
- TabWUseful  out  3  useful value.
- TabWMask  out  3  bit0 = ctr valid, bit1 = useful valid, bit2 = tag valid.
- UpdFull  out  1  queue full, to ctrl.
- UpdBusy  out  1  queue non-empty or FSM not IDLE.
- UpdDropCnt  out  8  saturating count of dropped records.

## Operation
- Record fields: Pc, provider {num, ctr, useful}, alloc {able, num, ctr, useful}, dec mask[6:1], dec values[6:1]. The record is captured when OutDateAble=1; the New* inputs are sampled in the same cycle.
- Dec mask bit k = NewCntkAble, forced to 0 when NewDateAble=1 and NewUpNum==k. The allocation write wins.
- Queue: circular, head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
  - Enqueue is allowed when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the record is dropped and UpdDropCnt increments, saturating at 255.
- FSM states: IDLE, PROV, ALLOC, DEC. The working record is held in registers.
  - IDLE: if count>0, pop the head into the working register and go to PROV.
  - PROV: TabWEn=1, TabWSel=prov num, ctr/useful from the provider fields.
    - Mask=3'b001 if num==0 (T0 has no useful), else 3'b011.
    - On TabWReady: go to ALLOC if alloc able, else DEC if mask≠0, else DONE.
  - ALLOC: TabWEn=1, TabWSel=alloc num, Mask=3'b111, ctr/useful from the alloc fields.
    - On TabWReady: go to DEC if mask≠0, else DONE.
  - DEC: write the lowest set mask bit k. TabWSel=k, TabWUseful=dec value k, Mask=3'b010.
    - On TabWReady: clear bit k. When the remaining mask is 0, DONE.
  - DONE (taken on the accepting edge, not a separate state): if count>0 (before this cycle's enqueue), pop and go to PROV with no bubble; else go to IDLE.
- TabWIdx and TabWTag derive from the working Pc for every write of the record.
- When TabWEn=1 and TabWReady=0, all Tab* outputs hold stable.
- UpdFull = (count==DEPTH).

## Timing
- Reset: count, pointers, FSM=IDLE, TabWEn=0, all Tab* outputs=0, UpdFull=0, UpdBusy=0, UpdDropCnt=0. An in-flight record and all queued records are discarded.
- Latency: a record enqueued at edge N, into an empty queue with the FSM in IDLE, produces its PROV write in cycle N+1 → N+2. The pop happens at edge N+1, and TabWEn is registered.
- Throughput: one write per TabWReady cycle. A record costs 1 + alloc + popcount(mask) accepted cycles.
- A pop and an enqueue in the same cycle leave count unchanged.
- With DEPTH entries queued plus one in the FSM, UpdFull=1. An enqueue is still accepted in the cycle where DONE pops.

## Test plan
- Single record: Pc=0x1C000040, prov num=2, ctr=5, useful=1, no alloc, no dec. Required: one write in cycle N+2 with Sel=2, Idx=0x10, Mask=3'b011, Ctr=5, Useful=1, then IDLE.
- Full record: prov num=1, alloc num=4 (ctr=4, useful=0), NewCnt2/3/4/5Able=1 with dec values 2,1,3,0. Required writes, in order: T1; T4 with Mask=3'b111; T2 Useful=2; T3 Useful=1; T5 Useful=0. The T4 dec is dropped.
- Stall: TabWReady=0 for 3 cycles during ALLOC. Required: outputs held for 3 cycles, then the write proceeds; no write is lost or duplicated.
- Overflow: DEPTH=4, TabWReady=0, 6 enqueues in 6 consecutive cycles. Required: 5 records held (4 in the queue plus 1 in the FSM), UpdFull=1, UpdDropCnt=1.
- Back-to-back: two queued base-only records (num=0). Required: the T0 writes occur in consecutive cycles with Mask=3'b001 and no IDLE bubble.
- Reset mid-DEC: assert Rest for one cycle. Required: next cycle TabWEn=0, UpdBusy=0, UpdDropCnt=0; a subsequent enqueue behaves as in the single-record case.
